// File: rtl/binary_subtractor_serial.sv
// Serial multi-cycle subtractor: computes a - b - in_borrow one SLICE-bit slice per clock,
// least-significant slice first, with valid/ready handshakes on both sides and
// unsigned borrow, signed overflow and zero flags on the result.
module binary_subtractor_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             out_borrow,
    output logic             overflow,
    output logic             zero
);

    // WIDTH must be a multiple of SLICE.
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLast = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    // Operands shift right one slice per RUN cycle so the active slice is always at the bottom.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // Sign bits of the captured operands, kept aside because the operand registers shift.
    logic             a_msb_q;
    logic             b_msb_q;
    logic             borrow_q;
    // Partial result; each new slice enters at the top and moves down, ending LSB-aligned.
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] difference_q;
    logic             out_borrow_q;
    logic             overflow_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_sub;
    logic             borrow_d;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             overflow_d;
    logic             zero_d;

    // Slice subtraction and next values of the shifting datapath registers.
    always_comb begin
        a_slice    = a_q[SLICE-1:0];
        b_slice    = b_q[SLICE-1:0];
        // One extra bit so the borrow out of the slice lands in the MSB.
        slice_sub  = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE{1'b0}}, borrow_q};
        borrow_d   = slice_sub[SLICE];
        work_d     = WIDTH'({slice_sub[SLICE-1:0], work_q} >> SLICE);
        a_d        = a_q >> SLICE;
        b_d        = b_q >> SLICE;
        // Only meaningful on the last slice, when work_d holds the complete difference.
        overflow_d = (a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
        zero_d     = (work_d == '0);
    end

    assign in_ready   = (state_q == StIdle) && !rst;
    assign out_valid  = out_valid_q;
    assign difference = difference_q;
    assign out_borrow = out_borrow_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;

    // Control FSM with registered result and flags; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            borrow_q     <= 1'b0;
            work_q       <= '0;
            difference_q <= '0;
            out_borrow_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        borrow_q <= in_borrow;
                        work_q   <= '0;
                        k_q      <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    work_q   <= work_d;
                    borrow_q <= borrow_d;
                    if (k_q == KLast) begin
                        k_q          <= '0;
                        difference_q <= work_d;
                        out_borrow_q <= borrow_d;
                        overflow_q   <= overflow_d;
                        zero_q       <= zero_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
